txline_term_cal: RTL and testbench
==================================

// Module: txline_term_cal
// PURPOSE
//  Successive-approximation (SAR) controller that calibrates the receiver termination (rt) of the
//  lossless txline model. Drives a test step via tx_en, waits for reflections to settle, samples a
//  comparator (received level vs. target), and bisects a termination code NBIT deep.
//  Sits between the link test sequencer (start/done) and the txline rt input (real domain).
// PARAMETERS
//  NBIT     4      width of termination code; NBIT trial cycles per calibration
//  RT_MIN   30.0   real; rt (ohm) at code 0
//  RT_STEP  2.0    real; rt increment (ohm) per code LSB
//  SETTLE   3      clock cycles waited after each trial update before sampling (>=1)
// PORTS
//  clk     in   1     clock; all state updates on rising edge
//  rst     in   1     asynchronous, active-high reset
//  start   in   1     calibration request; sampled in IDLE/DONE only
//  cmp     in   1     comparator: 1 = received level above target (rt too high)
//  tx_en   out  1     enables txline test drive; high while busy
//  code    out  NBIT  current/final termination code
//  rt      out  real  `output_real; RT_MIN + code*RT_STEP, updates same cycle as code
//  busy    out  1     calibration in progress
//  done    out  1     level; high from end of calibration until next accepted start or rst
//  sat     out  1     valid with done: final code == 0 or == 2^NBIT-1
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, code=2^(NBIT-1), rt=RT_MIN+2^(NBIT-1)*RT_STEP,
//   tx_en=busy=done=sat=0, bit index=NBIT-1, settle counter=0.
//  States: IDLE, SET, SETTLE, SAMPLE, DONE.
//  IDLE/DONE --start=1--> SET: code<=0, bit<=NBIT-1, busy<=1, tx_en<=1, done<=0, sat<=0.
//  SET (1 cycle): code[bit]<=1; -> SETTLE, counter<=SETTLE-1.
//  SETTLE: counter decrements each cycle; at 0 -> SAMPLE (exactly SETTLE cycles in state).
//  SAMPLE (1 cycle): if cmp==1 code[bit]<=0 else keep; if bit==0 -> DONE else bit<=bit-1, -> SET.
//  DONE entry: busy<=0, tx_en<=0, done<=1, sat<=(final code==0 || final code all ones).
//  Latency: start accepted at edge E0; done high after edge E0+NBIT*(SETTLE+2).
//  start while busy: ignored (no restart, no error). start held high in DONE: restarts next edge.
//  cmp sampled only in SAMPLE; cmp value in other states has no effect.
//  rt is a pure function of code (no extra register); changes only at clock edges.
//  Reset mid-calibration: abort immediately, outputs to reset values, partial code discarded.
//  Code arithmetic unsigned NBIT; no overflow possible (bit set/clear only).
// CONFIGURATION
//  Macro TXLINE_TERM_CAL_AVG_EN:
//   defined: SAMPLE lasts 3 cycles; cmp captured each cycle; decision = majority of 3 samples.
//            Latency becomes NBIT*(SETTLE+4).
//   undefined: single-sample SAMPLE as above (1 cycle).
// TESTING  (NBIT=4, RT_MIN=30.0, RT_STEP=2.0, SETTLE=3; bench model cmp = (rt > 50.0))
//  1 rst pulse mid-run -> code=8, rt=46.0, busy=tx_en=done=sat=0 asynchronously.
//  2 start 1 cycle -> trials 8,12,10,11 -> final code=10, rt=50.0, sat=0; done 20 cycles after start.
//  3 cmp forced 1 -> final code=0, rt=30.0, sat=1; cmp forced 0 -> code=15, rt=60.0, sat=1.
//  4 start pulsed at cycles 5 and 12 after first start -> ignored; result/latency as scenario 2.
//  5 rst asserted during SETTLE of bit 1, then new start -> clean run, code=10, 20-cycle latency.
//  6 AVG_EN: cmp glitches 1 for one cycle of each SAMPLE window -> code=10, done after 28 cycles.

Source files
------------

// File: rtl/txline_term_cal.sv
// txline_term_cal: SAR calibration of txline receiver termination (rt) against a comparator.
// Optional TXLINE_TERM_CAL_AVG_EN: 3-sample majority vote per trial decision. Rev 1.0
`default_nettype none

module txline_term_cal #(
  parameter int  NBIT    = 4,
  parameter real RT_MIN  = 30.0,
  parameter real RT_STEP = 2.0,
  parameter int  SETTLE  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_cmp,
  output logic            o_tx_en,
  output logic [NBIT-1:0] o_code,
  output real             o_rt,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_sat
);

  localparam int BW = (NBIT > 1) ? $clog2(NBIT) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_SET    = 3'd1;
  localparam logic [2:0] c_SETTLE = 3'd2;
  localparam logic [2:0] c_SAMPLE = 3'd3;
  localparam logic [2:0] c_DONE   = 3'd4;

  localparam logic [NBIT-1:0] c_CODE_MID = {1'b1, {(NBIT-1){1'b0}}};
  localparam logic [NBIT-1:0] c_ONE      = {{(NBIT-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0]   c_BIT_TOP  = BW'(NBIT-1);
  localparam logic [CW-1:0]   c_CNT_INIT = CW'(SETTLE-1);

  logic [2:0]      r_state;
  logic [NBIT-1:0] r_code;
  logic [BW-1:0]   r_bit;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_tx_en;
  logic            r_done;
  logic            r_sat;

  logic [NBIT-1:0] w_mask;
  logic [NBIT-1:0] w_code_smp;
  logic            w_last;
  logic            w_dec;

`ifdef TXLINE_TERM_CAL_AVG_EN
  logic [1:0] r_smp;
  logic [1:0] r_scnt;

  // Two samples are stored; the third is taken live on the deciding edge.
  assign w_last = (r_scnt == 2'd2);
  assign w_dec  = (r_smp[0] & r_smp[1]) | (r_smp[0] & i_cmp) | (r_smp[1] & i_cmp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_smp  <= 2'b00;
      r_scnt <= 2'd0;
    end else if (r_state == c_SAMPLE && !w_last) begin
      r_smp[r_scnt[0]] <= i_cmp;
      r_scnt           <= r_scnt + 2'd1;
    end else begin
      r_scnt <= 2'd0;
    end
  end
`else
  assign w_last = 1'b1;
  assign w_dec  = i_cmp;
`endif

  assign w_mask     = c_ONE << r_bit;
  assign w_code_smp = w_dec ? (r_code & ~w_mask) : r_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_code  <= c_CODE_MID;
      r_bit   <= c_BIT_TOP;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_tx_en <= 1'b0;
      r_done  <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE, c_DONE: begin
          if (i_start) begin
            r_state <= c_SET;
            r_code  <= '0;
            r_bit   <= c_BIT_TOP;
            r_busy  <= 1'b1;
            r_tx_en <= 1'b1;
            r_done  <= 1'b0;
            r_sat   <= 1'b0;
          end
        end
        c_SET: begin
          r_code  <= r_code | w_mask;
          r_cnt   <= c_CNT_INIT;
          r_state <= c_SETTLE;
        end
        c_SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= c_SAMPLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        c_SAMPLE: begin
          if (w_last) begin
            r_code <= w_code_smp;
            if (r_bit == '0) begin
              r_state <= c_DONE;
              r_busy  <= 1'b0;
              r_tx_en <= 1'b0;
              r_done  <= 1'b1;
              r_sat   <= (w_code_smp == '0) || (&w_code_smp);
            end else begin
              r_bit   <= r_bit - 1'b1;
              r_state <= c_SET;
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign o_code  = r_code;
  assign o_rt    = RT_MIN + RT_STEP * real'(r_code);
  assign o_busy  = r_busy;
  assign o_tx_en = r_tx_en;
  assign o_done  = r_done;
  assign o_sat   = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_txline_term_cal.sv
// tb_txline_term_cal: scoreboard bench for txline_term_cal with a behavioural rt > 50 ohm comparator.
`default_nettype none

module tb_txline_term_cal;

  localparam int NBIT   = 4;
  localparam int SETTLE = 3;
`ifdef TXLINE_TERM_CAL_AVG_EN
  localparam int LAT = NBIT * (SETTLE + 4);
`else
  localparam int LAT = NBIT * (SETTLE + 2);
`endif

  typedef struct {
    int code;
    int rt10;
    int sat;
    int lat;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            i_start;
  logic            i_cmp;
  logic            o_tx_en;
  logic [NBIT-1:0] o_code;
  real             o_rt;
  logic            o_busy;
  logic            o_done;
  logic            o_sat;

  int   cmp_mode;
  logic r_glitch;
  int   n_total;
  int   n_bad;
  exp_t sb[$];

  txline_term_cal #(
    .NBIT(NBIT), .RT_MIN(30.0), .RT_STEP(2.0), .SETTLE(SETTLE)
  ) u_dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_cmp(i_cmp),
    .o_tx_en(o_tx_en), .o_code(o_code), .o_rt(o_rt),
    .o_busy(o_busy), .o_done(o_done), .o_sat(o_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plant: mode 0 = received level above target when rt > 50 ohm, 1 = stuck high, 2 = stuck low.
  always_comb begin
    i_cmp = 1'b0;
    case (cmp_mode)
      1:       i_cmp = 1'b1;
      2:       i_cmp = 1'b0;
      default: i_cmp = (o_rt > 50.0);
    endcase
    if (r_glitch) i_cmp = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rt10(input real r);
    return $rtoi(r * 10.0 + 0.5);
  endfunction

  function automatic int sar_exp(input int mode);
    int c = 0;
    real r;
    bit cm;
    for (int b = NBIT - 1; b >= 0; b--) begin
      c = c | (1 << b);
      r = 30.0 + 2.0 * c;
      cm = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (r > 50.0);
      if (cm) c = c & ~(1 << b);
    end
    return c;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_code"}, 32'(o_code), 32'd8);
    chk({tag, "_rt10"}, rt10(o_rt), 460);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_txen"}, 32'(o_tx_en), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_sat"}, 32'(o_sat), 0);
  endtask

  task automatic run_cal(input string tag, input int mode, input bit pulses,
                         input bit glitch, input int abort_at);
    exp_t e;
    int cyc;
    cmp_mode = mode;
    @(negedge clk);
    i_start = 1'b1;
    e.code = sar_exp(mode);
    e.rt10 = 300 + 20 * e.code;
    e.sat  = (e.code == 0 || e.code == (1 << NBIT) - 1) ? 1 : 0;
    e.lat  = LAT;
    sb.push_back(e);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    cyc = 0;
    while (!o_done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      // Glitch lands on the first sample of every 3-cycle SAMPLE window.
      r_glitch = glitch && (cyc % 7 == 4);
      if (pulses) i_start = (cyc == 5 || cyc == 12);
      if (cyc == 1) begin
        chk({tag, "_busy_run"}, 32'(o_busy), 1);
        chk({tag, "_txen_run"}, 32'(o_tx_en), 1);
        chk({tag, "_done_run"}, 32'(o_done), 0);
      end
      if (cyc == abort_at) begin
        #1 rst = 1'b1;
        #1 check_reset_outputs({tag, "_abort"});
        void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b0;
        i_start = 1'b0;
        r_glitch = 1'b0;
        return;
      end
    end
    i_start = 1'b0;
    r_glitch = 1'b0;
    e = sb.pop_front();
    chk({tag, "_lat"}, cyc, e.lat);
    chk({tag, "_code"}, 32'(o_code), e.code);
    chk({tag, "_rt10"}, rt10(o_rt), e.rt10);
    chk({tag, "_sat"}, 32'(o_sat), e.sat);
    chk({tag, "_busy_end"}, 32'(o_busy), 0);
    chk({tag, "_txen_end"}, 32'(o_tx_en), 0);
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    cmp_mode = 0;
    r_glitch = 1'b0;
    i_start  = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    run_cal("abort_mid", 0, 1'b0, 1'b0, 7);
    run_cal("nominal", 0, 1'b0, 1'b0, 0);
    run_cal("cmp_hi", 1, 1'b0, 1'b0, 0);
    run_cal("cmp_lo", 2, 1'b0, 1'b0, 0);
    run_cal("start_busy", 0, 1'b1, 1'b0, 0);
    run_cal("abort_bit1", 0, 1'b0, 1'b0, 12);
    run_cal("after_abort", 0, 1'b0, 1'b0, 0);
`ifdef TXLINE_TERM_CAL_AVG_EN
    run_cal("avg_glitch", 0, 1'b0, 1'b1, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
